// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the performance-counter CSR logic:
// data width, counter identifiers, CSR addresses and the default snapshot lifetime.
package core_config_pkg;

  localparam int XLEN            = 32;
  localparam int PERF_SHADOW_TTL = 16;

  typedef enum logic [1:0] {
    PERF_CYC  = 2'd0,
    PERF_TIM  = 2'd1,
    PERF_RET  = 2'd2,
    PERF_NONE = 2'd3
  } perf_id_t;

  // User-level counters and their machine-mode aliases (time has no M alias).
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

endpackage

// File: rtl/perf_csr_decode.sv
// Combinational performance-counter CSR address decoder: address to
// {counter id, high-half flag, illegal}. Shared with the main CSR file.
module perf_csr_decode
  import core_config_pkg::*;
(
  input  logic [11:0] addr,
  output perf_id_t    id,
  output logic        is_high,
  output logic        illegal
);

  always_comb begin
    id      = PERF_NONE;
    is_high = 1'b0;
    illegal = 1'b0;
    case (addr)
      CSR_CYCLE, CSR_MCYCLE:       id = PERF_CYC;
      CSR_TIME:                    id = PERF_TIM;
      CSR_INSTRET, CSR_MINSTRET:   id = PERF_RET;
      CSR_CYCLEH, CSR_MCYCLEH: begin
        id      = PERF_CYC;
        is_high = 1'b1;
      end
      CSR_TIMEH: begin
        id      = PERF_TIM;
        is_high = 1'b1;
      end
      CSR_INSTRETH, CSR_MINSTRETH: begin
        id      = PERF_RET;
        is_high = 1'b1;
      end
      default:                     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/perf_csr_reader.sv
// Performance-counter CSR read port with a registered one-cycle response.
// Define PERF_SNAPSHOT_EN to add the low-half snapshot that makes lo/hi pairs tear-free.
module perf_csr_reader
  import core_config_pkg::*;
#(
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int SHADOW_TTL = PERF_SHADOW_TTL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] cyc_l,
  input  logic [XLEN-1:0] cyc_h,
  input  logic [XLEN-1:0] tim_l,
  input  logic [XLEN-1:0] tim_h,
  input  logic [XLEN-1:0] ret_l,
  input  logic [XLEN-1:0] ret_h,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  if (XLEN != 32) begin : g_bad_xlen
    $error("perf_csr_reader requires XLEN == 32");
  end
  if (SHADOW_TTL < 1 || SHADOW_TTL > 255) begin : g_bad_ttl
    $error("perf_csr_reader SHADOW_TTL must be in 1..255");
  end

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  perf_id_t        dec_id;
  logic            dec_high;
  logic            dec_illegal;
  logic [XLEN-1:0] live_lo;
  logic [XLEN-1:0] live_hi;
  logic [XLEN-1:0] hi_sel;
  logic            accept;

  perf_csr_decode u_decode (
    .addr    (req_addr),
    .id      (dec_id),
    .is_high (dec_high),
    .illegal (dec_illegal)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid && clk_en && (state_q == IDLE);

  always_comb begin
    live_lo = '0;
    live_hi = '0;
    case (dec_id)
      PERF_CYC: begin
        live_lo = cyc_l;
        live_hi = cyc_h;
      end
      PERF_TIM: begin
        live_lo = tim_l;
        live_hi = tim_h;
      end
      PERF_RET: begin
        live_lo = ret_l;
        live_hi = ret_h;
      end
      default: begin
        live_lo = '0;
        live_hi = '0;
      end
    endcase
  end

`ifdef PERF_SNAPSHOT_EN
  logic            shadow_vld_q, shadow_vld_d;
  perf_id_t        shadow_id_q, shadow_id_d;
  logic [7:0]      shadow_age_q, shadow_age_d;
  logic [XLEN-1:0] shadow_hi_q, shadow_hi_d;
  logic            shadow_hit;

  // Aliases decode to the same id, so a B00/C80 pair still matches.
  assign shadow_hit = shadow_vld_q && dec_high && !dec_illegal && (shadow_id_q == dec_id);
  assign hi_sel     = shadow_hit ? shadow_hi_q : live_hi;

  always_comb begin
    shadow_vld_d = shadow_vld_q;
    shadow_id_d  = shadow_id_q;
    shadow_age_d = shadow_age_q;
    shadow_hi_d  = shadow_hi_q;
    if (clk_en && shadow_vld_q) begin
      shadow_age_d = shadow_age_q - 8'd1;
      if (shadow_age_q == 8'd1) begin
        shadow_vld_d = 1'b0;
      end
    end
    // A fresh low-half read overrides expiry in the same cycle.
    if (accept && !dec_illegal) begin
      if (!dec_high) begin
        shadow_vld_d = 1'b1;
        shadow_id_d  = dec_id;
        shadow_age_d = 8'(SHADOW_TTL);
        shadow_hi_d  = live_hi;
      end else if (shadow_hit) begin
        shadow_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_vld_q <= 1'b0;
      shadow_id_q  <= PERF_NONE;
      shadow_age_q <= 8'd0;
      shadow_hi_q  <= '0;
    end else begin
      shadow_vld_q <= shadow_vld_d;
      shadow_id_q  <= shadow_id_d;
      shadow_age_q <= shadow_age_d;
      shadow_hi_q  <= shadow_hi_d;
    end
  end
`else
  assign hi_sel = live_hi;
`endif

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          if (dec_illegal) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            rsp_data_d = dec_high ? hi_sel : live_lo;
            rsp_err_d  = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_ready && clk_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: doc/perf_csr_reader.md
# perf_csr_reader

Performance-counter CSR read port sitting directly downstream of the three per-event `counter` instances (cycle, time, instret). Accepts CSR read requests from the execute stage over a valid/ready handshake and decodes the 12-bit CSR address. Returns the selected 32-bit half one cycle later. A low-half read snapshots the full 64-bit value, so a following high-half read returns a tear-free pair even if the counter carried between the two reads.

## Interface

Parameters:
- `XLEN`, `core_config_pkg::XLEN` (32): data width; block requires XLEN = 32 (dual-port counters).
- `SHADOW_TTL`, 16: cycles a snapshot stays valid after the low-half read; range 1..255.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `clk_en`  in  1  global clock enable; when 0, all state holds.
- `req_valid`  in  1  read request present.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  12  CSR address.
- `cyc_l`, `cyc_h`  in  XLEN each  cycle counter halves.
- `tim_l`, `tim_h`  in  XLEN each  time counter halves.
- `ret_l`, `ret_h`  in  XLEN each  instret counter halves.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  XLEN  read data.
- `rsp_err`  out  1  illegal/unmapped address.

## Operation

- FSM states: IDLE, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` && `clk_en`: decode `req_addr`, register `rsp_data`/`rsp_err`, go to RESP.
- RESP:
  - `req_ready` = 0; `rsp_valid` = 1; `rsp_data`/`rsp_err` held stable.
  - On `rsp_ready` && `clk_en`: go to IDLE.
- Address map:
  - Low halves: 0xC00/0xB00 → cycle, 0xC01 → time, 0xC02/0xB02 → instret.
  - High halves: 0xC80/0xB80 → cycle, 0xC81 → time, 0xC82/0xB82 → instret.
  - Any other address: `rsp_err` = 1, `rsp_data` = 0, shadow unaffected.
- Low-half read:
  - Returns live low half.
  - Captures live high half into `shadow_hi` and the counter id into `shadow_id`.
  - Sets `shadow_vld`; loads `shadow_age` = SHADOW_TTL.
- High-half read:
  - If `shadow_vld` and `shadow_id` matches: return `shadow_hi`, then clear `shadow_vld`.
  - Otherwise: return live high half.
- Shadow ageing:
  - `shadow_age` decrements each `clk_en` cycle while `shadow_vld`.
  - Reaching 0 clears `shadow_vld`.
  - A new low-half read in the same cycle as expiry wins: reload, stay valid.
- A low-half read of a different counter replaces the shadow.
- 0xC00 and 0xB00 share a counter id, and so on for the other aliases; cross-alias pairs are consistent.

## Timing

- Request accept to `rsp_valid`: 1 cycle. Throughput: one request per 2 cycles minimum.
- Counter inputs are sampled in the accept cycle.
- Reset values:
  - `req_ready` = 1; `rsp_valid` = 0; `rsp_data` = 0; `rsp_err` = 0.
  - `shadow_vld` = 0; `shadow_age` = 0; `shadow_hi` = 0.
- Reset asserted in RESP: the response is dropped and the FSM returns to IDLE.
- Backpressure: RESP holds indefinitely. The shadow keeps ageing while `clk_en` = 1.
- `clk_en` = 0: no accept, no response retire, no ageing.

## Configuration

- `PERF_SNAPSHOT_EN` defined:
  - Shadow register, id, age counter and the matching logic are present, as above.
- Not defined:
  - No shadow state; high-half reads always return the live value.
  - SHADOW_TTL is unused.
  - Latency and handshake are unchanged.

## Structure

- Belongs in `core_config_pkg`:
  - `perf_id_t` enum: PERF_CYC, PERF_TIM, PERF_RET, PERF_NONE.
  - CSR address constants.
  - `PERF_SHADOW_TTL` default.
- One sub-module, `perf_csr_decode`:
  - Combinational: address → {`perf_id_t`, is_high, illegal}.
  - Kept separate so the CSR file reuses it.

## Test plan

1. Reset mid-RESP (`rsp_ready` = 0) → next cycle `rsp_valid` = 0, `req_ready` = 1, `rsp_data` = 0.
2. Read 0xC00 with cyc = 0x00000001_FFFFFFFF, then the counter becomes 0x00000002_00000003, then read 0xC80 → responses 0xFFFFFFFF, then 0x00000001.
3. Same sequence with `PERF_SNAPSHOT_EN` undefined → second response 0x00000002.
4. Read 0xC02, wait SHADOW_TTL + 1 cycles, then read 0xC82 with ret_h = 7 → response 7 (live; shadow expired).
5. Read 0xC00, read 0xC01, then read 0xC80 with cyc_h = 9 → response 9 (id mismatch, live); `shadow_vld` still set for time.
6. Request 0x123 → `rsp_err` = 1, `rsp_data` = 0. Hold `rsp_ready` = 0 for 5 cycles → `rsp_valid` held, `req_ready` = 0 throughout.
